// File: rtl/aes_inv_cipher_ctrl.sv
// Sequencer for the AES-128 inverse cipher datapath: issues one state/word load command
// per cycle and owns the round-key index and done flag.
module aes_inv_cipher_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       AES_START,
   input  logic       keyexp_done,
   output logic       msg_ld,
   output logic       keyexp_start,
   output logic       state_ld,
   output logic [1:0] state_sel,
   output logic       word_ld,
   output logic [1:0] word_sel,
   output logic [3:0] round_idx,
   output logic       busy,
   output logic       AES_DONE
);

   typedef enum logic [3:0] {
      WAIT     = 4'd0,
      KEYEXP   = 4'd1,
      ARK_INIT = 4'd2,
      ISR      = 4'd3,
      ISB      = 4'd4,
      ARK      = 4'd5,
      IMC0     = 4'd6,
      IMC1     = 4'd7,
      IMC2     = 4'd8,
      IMC3     = 4'd9,
      DONE     = 4'd10
   } state_t;

   localparam logic [3:0] ROUND_MAX = 4'(ROUNDS);

   state_t state, state_nxt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= WAIT;
      else          state <= state_nxt;
   end

   // Index walks ROUNDS..0 as round keys are consumed; saturates at 0.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         round_idx <= ROUND_MAX;
      else if (state == WAIT && AES_START)
         round_idx <= ROUND_MAX;
      else if ((state == ARK_INIT || state == ARK) && round_idx != 4'd0)
         round_idx <= round_idx - 4'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT:     if (AES_START) state_nxt = KEYEXP;
         KEYEXP:   if (keyexp_done) state_nxt = ARK_INIT;
         ARK_INIT: state_nxt = ISR;
         ISR:      state_nxt = ISB;
         ISB:      state_nxt = ARK;
         ARK:      state_nxt = (round_idx == 4'd0) ? DONE : IMC0;
         IMC0:     state_nxt = IMC1;
         IMC1:     state_nxt = IMC2;
         IMC2:     state_nxt = IMC3;
         IMC3:     state_nxt = ISR;
         DONE:     if (!AES_START) state_nxt = WAIT;
         default:  state_nxt = WAIT;
      endcase
   end

   always_comb begin
      msg_ld       = 1'b0;
      keyexp_start = 1'b0;
      state_ld     = 1'b0;
      state_sel    = 2'd0;
      word_ld      = 1'b0;
      word_sel     = 2'd0;
      busy         = 1'b1;
      AES_DONE     = 1'b0;
      case (state)
         WAIT: begin
            busy         = 1'b0;
            msg_ld       = AES_START;
            keyexp_start = AES_START;
         end
         KEYEXP:   ;
         ARK_INIT: state_ld = 1'b1;
         ARK:      state_ld = 1'b1;
         ISR: begin
            state_ld  = 1'b1;
            state_sel = 2'd1;
         end
         ISB: begin
            state_ld  = 1'b1;
            state_sel = 2'd2;
         end
         IMC0: begin
            word_ld  = 1'b1;
            word_sel = 2'd0;
         end
         IMC1: begin
            word_ld  = 1'b1;
            word_sel = 2'd1;
         end
         IMC2: begin
            word_ld  = 1'b1;
            word_sel = 2'd2;
         end
         IMC3: begin
            word_ld  = 1'b1;
            word_sel = 2'd3;
         end
         DONE: begin
            busy     = 1'b0;
            AES_DONE = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl; a behavioural AES inverse datapath follows the
// controller's commands so a full FIPS-197 C.1 decryption exercises the sequence end to end.
module tb_aes_inv_cipher_ctrl;

   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

   logic       CLK = 1'b0;
   logic       RESET_N, AES_START, keyexp_done;
   logic       msg_ld, keyexp_start, state_ld, word_ld, busy, AES_DONE;
   logic [1:0] state_sel, word_sel;
   logic [3:0] round_idx;

   int checks = 0;
   int fails  = 0;

   aes_inv_cipher_ctrl #(.ROUNDS(10)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .AES_START(AES_START), .keyexp_done(keyexp_done),
      .msg_ld(msg_ld), .keyexp_start(keyexp_start), .state_ld(state_ld),
      .state_sel(state_sel), .word_ld(word_ld), .word_sel(word_sel),
      .round_idx(round_idx), .busy(busy), .AES_DONE(AES_DONE)
   );

   always #5 CLK = ~CLK;

   // raw: every output; obs: selects masked to their load strobes (don't-care otherwise)
   wire [14:0] raw = {msg_ld, keyexp_start, state_ld, state_sel, word_ld, word_sel,
                      busy, AES_DONE, round_idx};
   wire [14:0] obs = {msg_ld, keyexp_start, state_ld, state_ld ? state_sel : 2'd0,
                      word_ld, word_ld ? word_sel : 2'd0, busy, AES_DONE, round_idx};

   // ---------------- reference AES pieces ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gm(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int k);
      logic [7:0] r;
      r = (b << k) | (b >> (8 - k));
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isbox(input logic [7:0] a);
      return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] isr(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] isb(input logic [127:0] s);
      logic [127:0] o;
      for (int n = 0; n < 16; n++) o[8*n +: 8] = isbox(s[8*n +: 8]);
      return o;
   endfunction

   function automatic logic [31:0] imcw(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09),
              gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d),
              gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b),
              gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e)};
   endfunction

   logic [127:0] rk [0:10];
   logic [127:0] dp;

   task automatic expand_key();
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Behavioural datapath driven purely by the controller's command outputs
   always @(posedge CLK) begin
      if (msg_ld) dp <= CT;
      else if (state_ld) begin
         case (state_sel)
            2'd0:    dp <= dp ^ rk[round_idx];
            2'd1:    dp <= isr(dp);
            2'd2:    dp <= isb(dp);
            default: ;
         endcase
      end
      else if (word_ld) dp[32*word_sel +: 32] <= imcw(dp[32*word_sel +: 32]);
   end

   // ---------------- expected command sequence ----------------
   logic [14:0] exp_seq[$];

   function automatic logic [14:0] cmd(input logic sld, input logic [1:0] ssel,
                                       input logic wld, input logic [1:0] wsel,
                                       input logic [3:0] idx);
      return {1'b0, 1'b0, sld, ssel, wld, wsel, 1'b1, 1'b0, idx};
   endfunction

   task automatic build_seq();
      exp_seq.delete();
      exp_seq.push_back(cmd(1'b1, 2'd0, 1'b0, 2'd0, 4'd10));
      for (int r = 9; r >= 1; r--) begin
         exp_seq.push_back(cmd(1'b1, 2'd1, 1'b0, 2'd0, 4'(r)));
         exp_seq.push_back(cmd(1'b1, 2'd2, 1'b0, 2'd0, 4'(r)));
         exp_seq.push_back(cmd(1'b1, 2'd0, 1'b0, 2'd0, 4'(r)));
         for (int k = 0; k < 4; k++) exp_seq.push_back(cmd(1'b0, 2'd0, 1'b1, 2'(k), 4'(r - 1)));
      end
      exp_seq.push_back(cmd(1'b1, 2'd1, 1'b0, 2'd0, 4'd0));
      exp_seq.push_back(cmd(1'b1, 2'd2, 1'b0, 2'd0, 4'd0));
      exp_seq.push_back(cmd(1'b1, 2'd0, 1'b0, 2'd0, 4'd0));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RESET_N = 1'b1; AES_START = 1'b0; keyexp_done = 1'b0;
      #1 RESET_N = 1'b0;
      #1;
      checks++;
      if (raw !== 15'd10) begin fails++; $display("FAIL reset_no_edge: got %h want %h", raw, 15'd10); end
      repeat (3) tick();
      checks++;
      if (raw !== 15'd10) begin fails++; $display("FAIL reset_with_edge: got %h want %h", raw, 15'd10); end
      RESET_N = 1'b1;
      tick();
      checks++;
      if (raw !== 15'd10) begin fails++; $display("FAIL reset_release_idle: got %h want %h", raw, 15'd10); end
   endtask

   task automatic test_full_run();
      int n, bad;
      int arks[$];
      keyexp_done = 1'b1; AES_START = 1'b1;
      #1;
      checks++;
      if ({msg_ld, keyexp_start, busy} !== 3'b110) begin
         fails++; $display("FAIL start_cmds: got %b want 110", {msg_ld, keyexp_start, busy});
      end
      tick();
      AES_START = 1'b0;
      checks++;
      if ({msg_ld, keyexp_start, state_ld, word_ld, busy} !== 5'b00001 || round_idx !== 4'd10) begin
         fails++; $display("FAIL keyexp_entry: got %b idx %0d want 00001 idx 10",
                           {msg_ld, keyexp_start, state_ld, word_ld, busy}, round_idx);
      end
      tick();
      n = 0; bad = 0; arks.delete();
      while (!AES_DONE && n < 200) begin
         if (n >= 67 || obs !== exp_seq[n]) bad++;
         if (state_ld && state_sel == 2'd0) arks.push_back(int'(round_idx));
         tick();
         n++;
      end
      checks++;
      if (n !== 67) begin fails++; $display("FAIL run_latency: got %0d cycles want 67", n); end
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL run_sequence: got %0d bad cycles want 0", bad); end
      checks++;
      begin
         int ab;
         ab = (arks.size() == 11) ? 0 : 1;
         for (int i = 0; i < arks.size() && i < 11; i++) if (arks[i] != 10 - i) ab++;
         if (ab !== 0) begin fails++; $display("FAIL ark_idx_seq: got %0d entries, %0d wrong; want 10..0", arks.size(), ab); end
      end
      checks++;
      if (dp !== PT) begin fails++; $display("FAIL fips_c1_plaintext: got %h want %h", dp, PT); end
      checks++;
      if ({AES_DONE, busy} !== 2'b10) begin fails++; $display("FAIL done_flags: got %b want 10", {AES_DONE, busy}); end
      tick();
      checks++;
      if ({AES_DONE, busy, msg_ld} !== 3'b000) begin fails++; $display("FAIL done_to_wait: got %b want 000", {AES_DONE, busy, msg_ld}); end
   endtask

   task automatic test_keyexp_stall();
      int n, bad;
      keyexp_done = 1'b0; AES_START = 1'b1;
      tick();
      AES_START = 1'b0;
      bad = 0;
      for (int i = 0; i <= 20; i++) begin
         if ({msg_ld, keyexp_start, state_ld, word_ld, busy, AES_DONE} !== 6'b000010) bad++;
         if (i < 20) tick();
      end
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL keyexp_stall: got %0d bad cycles want 0", bad); end
      keyexp_done = 1'b1;
      tick();
      checks++;
      if (obs !== cmd(1'b1, 2'd0, 1'b0, 2'd0, 4'd10)) begin
         fails++; $display("FAIL keyexp_release: got %h want %h", obs, cmd(1'b1, 2'd0, 1'b0, 2'd0, 4'd10));
      end
      n = 0;
      while (!AES_DONE && n < 200) begin tick(); n++; end
      checks++;
      if (n !== 67 || dp !== PT) begin
         fails++; $display("FAIL stall_run: got %0d cycles pt %h want 67 pt %h", n, dp, PT);
      end
      tick();
   endtask

   task automatic test_start_hold();
      int n, bad;
      keyexp_done = 1'b1; AES_START = 1'b1;
      tick();
      n = 0;
      while (!AES_DONE && n < 300) begin
         if (round_idx == 4'd5 && AES_START) AES_START = 1'b0;
         tick();
         n++;
      end
      checks++;
      if (n !== 68 || dp !== PT) begin
         fails++; $display("FAIL start_drop_run: got %0d cycles pt %h want 68 pt %h", n, dp, PT);
      end
      AES_START = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({AES_DONE, busy, msg_ld, keyexp_start} !== 4'b1000) bad++;
      end
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL done_hold: got %0d bad cycles want 0", bad); end
      AES_START = 1'b0;
      tick();
      checks++;
      if ({AES_DONE, busy, msg_ld} !== 3'b000) begin fails++; $display("FAIL hold_release: got %b want 000", {AES_DONE, busy, msg_ld}); end
   endtask

   task automatic test_reset_midrun();
      int n;
      keyexp_done = 1'b1; AES_START = 1'b1;
      tick();
      AES_START = 1'b0;
      n = 0;
      while (!(word_ld && word_sel == 2'd2 && round_idx == 4'd3) && n < 200) begin tick(); n++; end
      checks++;
      if (n >= 200) begin fails++; $display("FAIL reach_imc2_r4: got timeout want IMC2"); end
      RESET_N = 1'b0;
      #1;
      checks++;
      if (raw !== 15'd10) begin fails++; $display("FAIL midrun_reset_async: got %h want %h", raw, 15'd10); end
      tick();
      RESET_N = 1'b1;
      tick();
      checks++;
      if (raw !== 15'd10) begin fails++; $display("FAIL midrun_reset_release: got %h want %h", raw, 15'd10); end
   endtask

   initial begin
      expand_key();
      build_seq();
      test_reset();
      test_full_run();
      test_keyexp_stall();
      test_start_hold();
      test_reset_midrun();
      test_full_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout want completion");
      $fatal(1);
   end

endmodule
